// File: rtl/sobel_edge_filter.sv
// sobel_edge_filter
// Three-stage Sobel edge-magnitude pipeline. It takes the 8-neighbour matrix
// from the 3x3 frame buffer and outputs |Gx| + |Gy| with the row/column tag.
// The result is saturated to P_PIXEL_DEPTH bits.
// I_ENABLE=0 freezes every stage. I_RESET is synchronous, active-high, and
// flushes the whole pipeline.
// Optional build macro SOBEL_THRESHOLD_EN: the output stage emits a binary
// pixel instead (all ones when the unsaturated magnitude >= P_THRESHOLD).
module sobel_edge_filter #(
    parameter int P_COLUMNS             = 640,
    parameter int P_ROWS                = 4,
    parameter int P_PIXEL_DEPTH         = 8,
    parameter int P_THRESHOLD           = 128,
    parameter int P_COLUMNS_BITS        = $clog2(P_COLUMNS),
    parameter int P_ROWS_BITS           = $clog2(P_ROWS),
    parameter int P_I_PIXEL_MATRIX_BITS = P_PIXEL_DEPTH * 8
) (
    input  logic                             I_CLK,
    input  logic                             I_RESET,
    input  logic                             I_ENABLE,
    input  logic                             I_VALID,
    input  logic [P_I_PIXEL_MATRIX_BITS-1:0] I_PIXEL_MATRIX,
    input  logic [P_COLUMNS_BITS-1:0]        I_COLUMN,
    input  logic [P_ROWS_BITS-1:0]           I_ROW,
    output logic                             O_VALID,
    output logic [P_PIXEL_DEPTH-1:0]         O_PIXEL,
    output logic [P_COLUMNS_BITS-1:0]        O_COLUMN,
    output logic [P_ROWS_BITS-1:0]           O_ROW
);

    localparam int D       = P_PIXEL_DEPTH;
    localparam int SUM_W   = D + 2;   // one kernel half: up to 4*(2^D-1)
    localparam int DIFF_W  = D + 3;   // signed difference of two halves
    localparam int MAG_W   = D + 3;   // |Gx| + |Gy|
    localparam int PIX_MAX = (2 ** D) - 1;

    // Absolute value of a kernel difference; the result always fits SUM_W bits.
    function automatic logic [SUM_W-1:0] abs_diff(input logic signed [DIFF_W-1:0] d);
        logic signed [DIFF_W-1:0] a;
        a = (d < 0) ? -d : d;
        return SUM_W'(a);
    endfunction

    // Clamp the magnitude to the pixel range instead of letting it wrap.
    function automatic logic [D-1:0] saturate(input logic [MAG_W-1:0] m);
        if (m > MAG_W'(PIX_MAX))
            return {D{1'b1}};
        else
            return D'(m);
    endfunction

    // Binary edge decision on the unsaturated magnitude.
    function automatic logic [D-1:0] binarise(input logic [MAG_W-1:0] m);
        return (m >= MAG_W'(P_THRESHOLD)) ? {D{1'b1}} : {D{1'b0}};
    endfunction

    // Neighbour pixels, MSB-first packing, centre excluded.
    logic [D-1:0] tl, t, tr, ml, mr, bl, b, br;
    assign tl = I_PIXEL_MATRIX[8*D-1 -: D];
    assign t  = I_PIXEL_MATRIX[7*D-1 -: D];
    assign tr = I_PIXEL_MATRIX[6*D-1 -: D];
    assign ml = I_PIXEL_MATRIX[5*D-1 -: D];
    assign mr = I_PIXEL_MATRIX[4*D-1 -: D];
    assign bl = I_PIXEL_MATRIX[3*D-1 -: D];
    assign b  = I_PIXEL_MATRIX[2*D-1 -: D];
    assign br = I_PIXEL_MATRIX[1*D-1 -: D];

    logic [SUM_W-1:0] gx_pos, gx_neg, gy_pos, gy_neg;

    // Kernel halves: weights 1-2-1 on each side of the centre.
    always_comb begin
        gx_pos = SUM_W'(tr) + (SUM_W'(mr) << 1) + SUM_W'(br);
        gx_neg = SUM_W'(tl) + (SUM_W'(ml) << 1) + SUM_W'(bl);
        gy_pos = SUM_W'(bl) + (SUM_W'(b)  << 1) + SUM_W'(br);
        gy_neg = SUM_W'(tl) + (SUM_W'(t)  << 1) + SUM_W'(tr);
    end

    // ---- stage 1 boundary: partial sums, valid and tags ----
    logic [SUM_W-1:0]          gx_pos_p0, gx_neg_p0, gy_pos_p0, gy_neg_p0;
    logic                      vld_p0;
    logic [P_COLUMNS_BITS-1:0] col_p0;
    logic [P_ROWS_BITS-1:0]    row_p0;

    // Stage 1 register: capture partial sums while the pipeline advances.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            vld_p0    <= 1'b0;
            gx_pos_p0 <= '0;
            gx_neg_p0 <= '0;
            gy_pos_p0 <= '0;
            gy_neg_p0 <= '0;
            col_p0    <= '0;
            row_p0    <= '0;
        end else if (I_ENABLE) begin
            vld_p0    <= I_VALID;
            gx_pos_p0 <= gx_pos;
            gx_neg_p0 <= gx_neg;
            gy_pos_p0 <= gy_pos;
            gy_neg_p0 <= gy_neg;
            col_p0    <= I_COLUMN;
            row_p0    <= I_ROW;
        end
    end

    logic signed [DIFF_W-1:0] gx_diff, gy_diff;

    // Signed kernel differences; one spare bit keeps the sign.
    always_comb begin
        gx_diff = $signed({1'b0, gx_pos_p0}) - $signed({1'b0, gx_neg_p0});
        gy_diff = $signed({1'b0, gy_pos_p0}) - $signed({1'b0, gy_neg_p0});
    end

    // ---- stage 2 boundary: absolute gradients ----
    logic [SUM_W-1:0]          gx_abs_p1, gy_abs_p1;
    logic                      vld_p1;
    logic [P_COLUMNS_BITS-1:0] col_p1;
    logic [P_ROWS_BITS-1:0]    row_p1;

    // Stage 2 register: |Gx| and |Gy| with the matching valid and tags.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            vld_p1    <= 1'b0;
            gx_abs_p1 <= '0;
            gy_abs_p1 <= '0;
            col_p1    <= '0;
            row_p1    <= '0;
        end else if (I_ENABLE) begin
            vld_p1    <= vld_p0;
            gx_abs_p1 <= abs_diff(gx_diff);
            gy_abs_p1 <= abs_diff(gy_diff);
            col_p1    <= col_p0;
            row_p1    <= row_p0;
        end
    end

    logic [MAG_W-1:0] mag;
    logic [D-1:0]     pix_next;

    // Edge magnitude and the selected output mapping.
    always_comb begin
        mag = MAG_W'(gx_abs_p1) + MAG_W'(gy_abs_p1);
`ifdef SOBEL_THRESHOLD_EN
        pix_next = binarise(mag);
`else
        pix_next = saturate(mag);
`endif
    end

    // ---- stage 3 boundary: output register ----
    logic                      vld_p2;
    logic [D-1:0]              pix_p2;
    logic [P_COLUMNS_BITS-1:0] col_p2;
    logic [P_ROWS_BITS-1:0]    row_p2;

    // Output register: holds the last result while frozen.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            vld_p2 <= 1'b0;
            pix_p2 <= '0;
            col_p2 <= '0;
            row_p2 <= '0;
        end else if (I_ENABLE) begin
            vld_p2 <= vld_p1;
            pix_p2 <= pix_next;
            col_p2 <= col_p1;
            row_p2 <= row_p1;
        end
    end

    assign O_VALID  = vld_p2;
    assign O_PIXEL  = pix_p2;
    assign O_COLUMN = col_p2;
    assign O_ROW    = row_p2;

endmodule
